// File: rtl/writeback_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_buffer_pkg
// Description : Shared types for the writeback buffer: basic word/register
//               types, the memory-stage payload and the buffered/committed
//               writeback entry, plus helpers used at enqueue time.
// Revision    : 1.0 - initial multi-lane writeback buffer
// ============================================================================
package writeback_buffer_pkg;

  typedef logic [63:0] u64;
  typedef logic [4:0]  creg_addr_t;

  typedef struct packed {
    logic regwrite;
  } ctl_t;

  typedef struct packed {
    u64          pc;
    logic [31:0] raw_instr;
    creg_addr_t  dst;
    ctl_t        ctl;
    u64          writedata;
    u64          memaddr;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    u64          pc;
    logic [31:0] raw_instr;
    creg_addr_t  dst;
    logic        wen;
    u64          writedata;
    u64          memaddr;
  } wb_entry_t;

  // A lane carries a real instruction only if it is flagged valid and is not
  // an all-zero bubble.
  function automatic logic is_live(logic v, memory_data_t d);
    return v && (d.raw_instr != 32'd0);
  endfunction

  // x0 is hard-wired zero, so a write to it is turned into a non-write here
  // once, and nothing downstream has to special-case it.
  function automatic wb_entry_t make_entry(memory_data_t d);
    wb_entry_t e;
    e.valid     = 1'b1;
    e.pc        = d.pc;
    e.raw_instr = d.raw_instr;
    e.dst       = d.dst;
    e.wen       = d.ctl.regwrite && (d.dst != '0);
    e.writedata = d.writedata;
    e.memaddr   = d.memaddr;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_buffer_compact.sv
`default_nettype none
// ============================================================================
// Module      : wb_compact
// Description : Combinational lane compactor. Drops bubble lanes and packs the
//               live lanes, in lane order, into the low entry slots.
// Ports       : in_valid/in_data - per-lane memory-stage input
//               live_count       - number of live lanes
//               entries          - compacted entries, slots >= live_count zero
// Revision    : 1.0 - initial multi-lane writeback buffer
// ============================================================================
module wb_compact
  import writeback_buffer_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] in_valid,
  input  memory_data_t     in_data [LANES],
  output logic [CW-1:0]    live_count,
  output wb_entry_t        entries [LANES]
);

  always_comb begin
    int n;
    n = 0;
    for (int k = 0; k < LANES; k++) begin
      entries[k] = '0;
    end
    for (int k = 0; k < LANES; k++) begin
      if (is_live(in_valid[k], in_data[k])) begin
        entries[n] = make_entry(in_data[k]);
        n = n + 1;
      end
    end
    live_count = CW'(n);
  end

endmodule
`default_nettype wire

// File: rtl/writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : writeback_buffer
// Description : In-order circular writeback buffer. Accepts up to LANES
//               retiring instructions per cycle (bubbles dropped), commits up
//               to LANES per cycle in program order to the register file and
//               commit interface, forwards pending results to decode and
//               counts retired instructions.
// Ports       : clk, reset (async, active-low)
//               in_valid/in_data/in_ready - memory-stage input
//               stall                     - freeze commit (enqueue allowed)
//               rf_wen/rf_waddr/rf_wdata  - register-file write ports
//               commit                    - committed entries per lane
//               fwd_ra/fwd_hit/fwd_data   - forwarding lookup (2 ports)
//               instret                   - retired-instruction counter
// Revision    : 1.0 - initial multi-lane writeback buffer
// ============================================================================
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] in_valid,
  input  memory_data_t     in_data [LANES],
  output logic             in_ready,
  input  logic             stall,
  output logic [LANES-1:0] rf_wen,
  output creg_addr_t       rf_waddr [LANES],
  output u64               rf_wdata [LANES],
  output wb_entry_t        commit [LANES],
  input  creg_addr_t       fwd_ra [2],
  output logic [1:0]       fwd_hit,
  output u64               fwd_data [2],
  output logic [63:0]      instret
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(LANES + 1);

  wb_entry_t         buffer [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic [LW-1:0]     live_count;
  wb_entry_t         entries [LANES];
  logic              enq;
  logic [CW-1:0]     enq_n;
  logic [CW-1:0]     n_commit;

  wb_compact #(
    .LANES (LANES),
    .CW    (LW)
  ) u_compact (
    .in_valid   (in_valid),
    .in_data    (in_data),
    .live_count (live_count),
    .entries    (entries)
  );

  // Acceptance depends on registered occupancy only, so the memory stage
  // never sees a combinational path from its own data back to in_ready.
  assign in_ready = (count <= CW'(DEPTH - LANES));
  assign enq      = in_ready && (live_count != '0);
  assign enq_n    = enq ? CW'(live_count) : '0;

  always_comb begin
    if (stall) begin
      n_commit = '0;
    end else if (count < CW'(LANES)) begin
      n_commit = count;
    end else begin
      n_commit = CW'(LANES);
    end
  end

  // Commit lanes come straight from the oldest entries; unused lanes are zero
  // so lane k valid always implies lanes below k valid.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      commit[k] = '0;
      if (CW'(k) < n_commit) begin
        commit[k] = buffer[head + PW'(k)];
      end
      rf_wen[k]   = commit[k].valid && commit[k].wen;
      rf_waddr[k] = commit[k].dst;
      rf_wdata[k] = commit[k].writedata;
    end
  end

  // Scan oldest to youngest so the last match (youngest) is what remains.
  // wen is already cleared for x0, so fwd_ra == 0 can never hit.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fwd_hit[i]  = 1'b0;
      fwd_data[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if ((CW'(j) < count) &&
            buffer[head + PW'(j)].wen &&
            (buffer[head + PW'(j)].dst == fwd_ra[i])) begin
          fwd_hit[i]  = 1'b1;
          fwd_data[i] = buffer[head + PW'(j)].writedata;
        end
      end
    end
  end

  // Entry storage carries no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int k = 0; k < LANES; k++) begin
        if (LW'(k) < live_count) begin
          buffer[tail + PW'(k)] <= entries[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      instret <= '0;
    end else begin
      head    <= head + PW'(n_commit);
      tail    <= tail + PW'(enq_n);
      count   <= count + enq_n - n_commit;
      instret <= instret + 64'(n_commit);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (n_commit <= count);
      assert ((int'(count) + int'(enq_n) - int'(n_commit)) <= DEPTH);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_buffer
// Description : Self-checking bench for writeback_buffer (LANES=2, DEPTH=4)
//               using a queue-based reference model of the pending entries.
// Revision    : 1.0 - initial multi-lane writeback buffer
// ============================================================================
module tb_writeback_buffer;
  import writeback_buffer_pkg::*;

  logic         clk;
  logic         reset;
  logic [1:0]   in_valid;
  memory_data_t in_data [2];
  logic         in_ready;
  logic         stall;
  logic [1:0]   rf_wen;
  creg_addr_t   rf_waddr [2];
  u64           rf_wdata [2];
  wb_entry_t    commit [2];
  creg_addr_t   fwd_ra [2];
  logic [1:0]   fwd_hit;
  u64           fwd_data [2];
  logic [63:0]  instret;

  int           total;
  int           bad;
  wb_entry_t    q [$];
  logic [63:0]  retired;

  writeback_buffer #(
    .LANES (2),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .stall    (stall),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .commit   (commit),
    .fwd_ra   (fwd_ra),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .instret  (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_entry(input string tag, input wb_entry_t obs, input wb_entry_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic memory_data_t md(input u64 pc, input logic [31:0] raw,
                                      input creg_addr_t dst, input logic rw, input u64 data);
    memory_data_t d;
    d.pc           = pc;
    d.raw_instr    = raw;
    d.dst          = dst;
    d.ctl.regwrite = rw;
    d.writedata    = data;
    d.memaddr      = pc + 64'h100;
    return d;
  endfunction

  function automatic wb_entry_t expect_entry(input memory_data_t d);
    wb_entry_t e;
    e.valid     = 1'b1;
    e.pc        = d.pc;
    e.raw_instr = d.raw_instr;
    e.dst       = d.dst;
    e.wen       = d.ctl.regwrite && (d.dst != 5'd0);
    e.writedata = d.writedata;
    e.memaddr   = d.memaddr;
    return e;
  endfunction

  function automatic bit model_ready();
    return (4 - q.size()) >= 2;
  endfunction

  function automatic int model_ncommit();
    if (stall) return 0;
    return (q.size() < 2) ? q.size() : 2;
  endfunction

  // Compare every output against the model for the current cycle.
  task automatic check_outputs();
    int n;
    wb_entry_t e;
    logic h;
    u64 d;
    #1;
    n = model_ncommit();
    for (int k = 0; k < 2; k++) begin
      e = (k < n) ? q[k] : '0;
      chk_entry("commit", commit[k], e);
      chk("rf_wen", 64'(rf_wen[k]), 64'(e.valid & e.wen));
      if (k < n) begin
        chk("rf_waddr", 64'(rf_waddr[k]), 64'(e.dst));
        chk("rf_wdata", rf_wdata[k], e.writedata);
      end
    end
    chk("in_ready", 64'(in_ready), 64'(model_ready()));
    chk("instret", instret, retired);
    for (int i = 0; i < 2; i++) begin
      h = 1'b0;
      d = '0;
      for (int j = 0; j < q.size(); j++) begin
        if (fwd_ra[i] != 5'd0 && q[j].dst == fwd_ra[i] && q[j].wen) begin
          h = 1'b1;
          d = q[j].writedata;
        end
      end
      chk("fwd_hit", 64'(fwd_hit[i]), 64'(h));
      chk("fwd_data", fwd_data[i], d);
    end
  endtask

  task automatic update_model();
    int n;
    bit acc;
    n   = model_ncommit();
    acc = model_ready();
    for (int k = 0; k < n; k++) begin
      void'(q.pop_front());
      retired++;
    end
    if (acc) begin
      for (int k = 0; k < 2; k++) begin
        if (in_valid[k] && in_data[k].raw_instr != 32'd0) q.push_back(expect_entry(in_data[k]));
      end
    end
  endtask

  task automatic step();
    check_outputs();
    update_model();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int sent;
    total      = 0;
    bad        = 0;
    retired    = '0;
    reset      = 1'b0;
    stall      = 1'b0;
    in_valid   = 2'b00;
    in_data[0] = '0;
    in_data[1] = '0;
    fwd_ra[0]  = 5'd0;
    fwd_ra[1]  = 5'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_commit0_valid", 64'(commit[0].valid), 64'd0);
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_instret", instret, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // single live lane, lane1 bubble
    in_valid   = 2'b11;
    in_data[0] = md(64'h1000, 32'h01000293, 5'd5, 1'b1, 64'h10);
    in_data[1] = md(64'h1004, 32'h0, 5'd6, 1'b1, 64'h99);
    step();
    in_valid = 2'b00;
    #1;
    chk("single_c0_valid", 64'(commit[0].valid), 64'd1);
    chk("single_c0_dst", 64'(commit[0].dst), 64'd5);
    chk("single_c0_data", commit[0].writedata, 64'h10);
    chk("single_c1_valid", 64'(commit[1].valid), 64'd0);
    step();
    #1;
    chk("single_instret", instret, 64'd1);

    // fill under stall, then release
    stall      = 1'b1;
    in_valid   = 2'b11;
    in_data[0] = md(64'h2000, 32'h00000013, 5'd1, 1'b1, 64'h21);
    in_data[1] = md(64'h2004, 32'h00000013, 5'd2, 1'b1, 64'h22);
    step();
    in_data[0] = md(64'h2008, 32'h00000013, 5'd3, 1'b1, 64'h23);
    in_data[1] = md(64'h200c, 32'h00000013, 5'd4, 1'b1, 64'h24);
    step();
    #1;
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    in_data[0] = md(64'h2010, 32'h00000013, 5'd5, 1'b1, 64'h25);
    in_data[1] = md(64'h2014, 32'h00000013, 5'd6, 1'b1, 64'h26);
    step();
    stall    = 1'b0;
    in_valid = 2'b00;
    #1;
    chk("drain_c0_pc", commit[0].pc, 64'h2000);
    chk("drain_c1_pc", commit[1].pc, 64'h2004);
    step();
    step();
    step();
    #1;
    chk("drain_empty", 64'(commit[0].valid), 64'd0);

    // forwarding: youngest of two x3 writers wins, ra=0 never hits
    stall      = 1'b1;
    in_valid   = 2'b11;
    in_data[0] = md(64'h3000, 32'h00100193, 5'd3, 1'b1, 64'h1);
    in_data[1] = md(64'h3004, 32'h00200193, 5'd3, 1'b1, 64'h2);
    step();
    in_valid  = 2'b00;
    fwd_ra[0] = 5'd3;
    fwd_ra[1] = 5'd0;
    #1;
    chk("fwd_hit0", 64'(fwd_hit[0]), 64'd1);
    chk("fwd_data0", fwd_data[0], 64'h2);
    chk("fwd_hit1", 64'(fwd_hit[1]), 64'd0);
    step();
    stall = 1'b0;
    step();
    step();

    // x0 write: committed, no regfile write, no forwarding hit
    in_valid   = 2'b01;
    in_data[0] = md(64'h4000, 32'h00500013, 5'd0, 1'b1, 64'h55);
    fwd_ra[0]  = 5'd0;
    step();
    in_valid = 2'b00;
    #1;
    chk("x0_valid", 64'(commit[0].valid), 64'd1);
    chk("x0_rf_wen", 64'(rf_wen[0]), 64'd0);
    chk("x0_fwd_hit", 64'(fwd_hit[0]), 64'd0);
    step();

    // reset with three buffered entries
    stall      = 1'b1;
    in_valid   = 2'b11;
    in_data[0] = md(64'h4100, 32'h00000013, 5'd7, 1'b1, 64'h71);
    in_data[1] = md(64'h4104, 32'h00000013, 5'd8, 1'b1, 64'h72);
    step();
    in_valid   = 2'b01;
    in_data[0] = md(64'h4108, 32'h00000013, 5'd9, 1'b1, 64'h73);
    step();
    in_valid  = 2'b00;
    fwd_ra[0] = 5'd7;
    stall     = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_c0_valid", 64'(commit[0].valid), 64'd0);
    chk("mrst_rf_wen", 64'(rf_wen), 64'd0);
    chk("mrst_fwd_hit", 64'(fwd_hit[0]), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_instret", instret, 64'd0);
    q.delete();
    retired = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_instret", instret, 64'd0);
    @(negedge clk);

    // wrap-around: 10 sequential instructions, random one-cycle stalls
    sent = 0;
    for (int it = 0; it < 100 && sent < 10; it++) begin
      stall      = 1'($urandom_range(0, 1));
      in_valid   = 2'b01;
      in_data[0] = md(64'h5000 + 64'(sent * 4), 32'h00000013, 5'(sent + 1), 1'b1, 64'(sent));
      if (model_ready()) sent++;
      step();
    end
    in_valid = 2'b00;
    stall    = 1'b0;
    for (int it = 0; it < 6; it++) step();
    #1;
    chk("wrap_instret", instret, 64'd10);

    // random traffic
    for (int it = 0; it < 80; it++) begin
      stall    = ($urandom_range(0, 3) == 0);
      in_valid = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        in_data[k] = md({32'($urandom), 32'($urandom)},
                        ($urandom_range(0, 3) == 0) ? 32'h0 : (32'($urandom) | 32'h1),
                        5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        {32'($urandom), 32'($urandom)});
      end
      fwd_ra[0] = 5'($urandom_range(0, 7));
      fwd_ra[1] = 5'($urandom_range(0, 7));
      step();
    end
    in_valid = 2'b00;
    stall    = 1'b0;
    for (int it = 0; it < 4; it++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
